// File: rtl/cluster_fifo_packer.sv
// cluster_fifo_packer
// Samples the eight multiplexed cluster lanes once per mux half, packs the
// leading valid lanes two at a time into a pair-wide FIFO, and drains them as
// one cluster per cycle on a valid/ready stream with first-word-fall-through.
// Optional feature macro: CLUSTER_PACKER_OVF_CNT_EN enables the saturating
// dropped-pair counter on ovf_cnt; without it ovf_cnt is tied to zero.
module cluster_fifo_packer #(
  parameter int         FIFO_AW   = 4,
  parameter logic [1:0] CAP_PHASE = 2'd3
) (
  input  logic        clock4x,
  input  logic        global_reset,
  input  logic [87:0] adr_in,
  input  logic [23:0] cnt_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [10:0] out_adr,
  output logic [2:0]  out_cnt,
  output logic        out_sof,
  output logic        fifo_full,
  output logic        overflow,
  output logic [15:0] ovf_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, PAIR0, PAIR1, PAIR2, PAIR3} unload_state_t;

  typedef struct packed {
    logic        sof;
    logic        v1;
    logic        v0;
    logic [2:0]  cnt1;
    logic [10:0] adr1;
    logic [2:0]  cnt0;
    logic [10:0] adr0;
  } pair_t;

  logic [2:0]         phase;
  unload_state_t      state;
  logic [10:0]        snap_adr [8];
  logic [2:0]         snap_cnt [8];
  logic [7:0]         snap_valid;
  pair_t              mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               half;

  logic               capture;
  logic               in_pair;
  logic [1:0]         pair_idx;
  logic [2:0]         lo_lane;
  logic [2:0]         hi_lane;
  logic               push_req;
  logic               push;
  logic               drop;
  pair_t              push_entry;
  logic               head_v1;
  logic               pop;
  logic               adv_half;
  logic               half_n;
  logic               hi_sel;
  logic [FIFO_AW-1:0] rd_ptr_n;
  logic [FIFO_AW:0]   count_n;
  logic [FIFO_AW:0]   avail;
  pair_t              next_head;

  assign capture = (phase[1:0] == CAP_PHASE);
  assign lo_lane = {pair_idx, 1'b0};
  assign hi_lane = {pair_idx, 1'b1};

  // Decode which lane pair the unloader is looking at and build its FIFO entry
  always_comb begin
    in_pair  = 1'b1;
    pair_idx = 2'd0;
    case (state)
      PAIR0:   pair_idx = 2'd0;
      PAIR1:   pair_idx = 2'd1;
      PAIR2:   pair_idx = 2'd2;
      PAIR3:   pair_idx = 2'd3;
      default: in_pair  = 1'b0;
    endcase
    push_entry      = '0;
    push_entry.sof  = (pair_idx == 2'd0);
    push_entry.v1   = snap_valid[hi_lane];
    push_entry.v0   = snap_valid[lo_lane];
    push_entry.cnt1 = snap_cnt[hi_lane];
    push_entry.adr1 = snap_adr[hi_lane];
    push_entry.cnt0 = snap_cnt[lo_lane];
    push_entry.adr0 = snap_adr[lo_lane];
    push_req        = in_pair & snap_valid[lo_lane];
  end

  assign push = push_req & ~fifo_full;
  assign drop = push_req & fifo_full;

  // Read-side bookkeeping: handshake decode, pointer/occupancy next values and the entry to present next
  always_comb begin
    head_v1  = mem[rd_ptr].v1;
    pop      = out_valid & out_ready & (half | ~head_v1);
    adv_half = out_valid & out_ready & ~half & head_v1;
    rd_ptr_n = pop ? rd_ptr + PTR_ONE : rd_ptr;
    half_n   = pop ? 1'b0 : (adv_half | half);
    count_n  = count;
    if (push && !pop) begin
      count_n = count + CNT_ONE;
    end else if (!push && pop) begin
      count_n = count - CNT_ONE;
    end
    avail     = count - (pop ? CNT_ONE : '0);
    next_head = mem[rd_ptr_n];
    hi_sel    = half_n & next_head.v1;
  end

  // Frame phase counter, aligned with the upstream mux by sharing its reset value
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      phase <= 3'd1;
    end else begin
      phase <= phase + 3'd1;
    end
  end

  // Snapshot capture and pair unloader; a capture always restarts at PAIR0
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state      <= IDLE;
      snap_valid <= '0;
    end else if (capture) begin
      state <= PAIR0;
      for (int i = 0; i < 8; i++) begin
        snap_adr[i]   <= adr_in[i*11 +: 11];
        snap_cnt[i]   <= cnt_in[i*3 +: 3];
        snap_valid[i] <= (adr_in[i*11+9 +: 2] != 2'b11);
      end
    end else begin
      case (state)
        PAIR0:   state <= push_req ? PAIR1 : IDLE;
        PAIR1:   state <= push_req ? PAIR2 : IDLE;
        PAIR2:   state <= push_req ? PAIR3 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy is cleared
  always_ff @(posedge clock4x) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers, occupancy, registered full flag and sticky overflow
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      fifo_full <= (count_n == CNT_FULL);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Output stage: presents the head entry's current half, held while stalled
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      out_valid <= 1'b0;
      out_adr   <= '0;
      out_cnt   <= '0;
      out_sof   <= 1'b0;
      half      <= 1'b0;
    end else begin
      half      <= half_n;
      out_valid <= (avail != '0);
      if (avail != '0) begin
        if (hi_sel) begin
          out_adr <= next_head.adr1;
          out_cnt <= next_head.cnt1;
          out_sof <= 1'b0;
        end else begin
          out_adr <= next_head.adr0;
          out_cnt <= next_head.cnt0;
          out_sof <= next_head.sof & next_head.v0;
        end
      end
    end
  end

`ifdef CLUSTER_PACKER_OVF_CNT_EN
  logic [15:0] drop_count;

  // Saturating count of dropped pairs, cleared only by reset
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      drop_count <= 16'h0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign ovf_cnt = drop_count;
`else
  assign ovf_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_cluster_fifo_packer.sv
// tb_cluster_fifo_packer
// Drives directed and randomized lane snapshots into cluster_fifo_packer and
// compares every cycle against a transaction-level model: a capture turns the
// leading valid lanes into pair writes on the following edges, pairs are kept
// or dropped by pair occupancy, and clusters are offered in order from the
// cycle after the edge that follows their write.
module tb_cluster_fifo_packer;

  logic        clock4x;
  logic        global_reset;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_adr;
  logic [2:0]  out_cnt;
  logic        out_sof;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] ovf_cnt;

  cluster_fifo_packer dut (
    .clock4x      (clock4x),
    .global_reset (global_reset),
    .adr_in       (adr_in),
    .cnt_in       (cnt_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_adr      (out_adr),
    .out_cnt      (out_cnt),
    .out_sof      (out_sof),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .ovf_cnt      (ovf_cnt)
  );

  // Free-running 10 ns clock
  initial begin
    clock4x = 1'b0;
    forever #5 clock4x = ~clock4x;
  end

  typedef struct {
    logic [10:0] adr;
    logic [2:0]  cnt;
    bit          sof;
    bit          last;
    int          wr_edge;
  } clu_t;

  typedef struct {
    int   at;
    clu_t lo;
    clu_t hi;
    bit   has_hi;
  } wr_t;

  clu_t fq[$];
  wr_t  sched[$];
  int   edge_no;
  int   ph;
  int   occ;
  int   m_drops;
  bit   m_full;
  bit   m_ovf;
  bit   m_offer;

  int   checks;
  int   errors;
  int   hs;

  function automatic logic [10:0] lane_adr(input int i);
    return adr_in[i*11 +: 11];
  endfunction

  function automatic logic [2:0] lane_cnt(input int i);
    return cnt_in[i*3 +: 3];
  endfunction

  function automatic logic [15:0] exp_ovf();
`ifdef CLUSTER_PACKER_OVF_CNT_EN
    return 16'(m_drops);
`else
    return 16'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    wr_t  w;
    clu_t c;
    int   n;
    edge_no++;
    if (global_reset) begin
      fq.delete();
      sched.delete();
      occ     = 0;
      ph      = 1;
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
      m_offer = 1'b0;
      return;
    end
    if (m_offer && out_ready) begin
      c = fq.pop_front();
      if (c.last) occ--;
    end
    if (sched.size() > 0 && sched[0].at == edge_no) begin
      w = sched.pop_front();
      if (m_full) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end else begin
        w.lo.wr_edge = edge_no;
        fq.push_back(w.lo);
        if (w.has_hi) begin
          w.hi.wr_edge = edge_no;
          fq.push_back(w.hi);
        end
        occ++;
      end
    end
    if ((ph % 4) == 3) begin
      sched.delete();
      n = 0;
      while (n < 8 && lane_adr(n) < 11'd1536) n++;
      for (int k = 0; 2*k < n; k++) begin
        w.at         = edge_no + 1 + k;
        w.has_hi     = (2*k + 1 < n);
        w.lo.adr     = lane_adr(2*k);
        w.lo.cnt     = lane_cnt(2*k);
        w.lo.sof     = (k == 0);
        w.lo.last    = !w.has_hi;
        w.lo.wr_edge = 0;
        w.hi.adr     = lane_adr(2*k + 1);
        w.hi.cnt     = lane_cnt(2*k + 1);
        w.hi.sof     = 1'b0;
        w.hi.last    = 1'b1;
        w.hi.wr_edge = 0;
        sched.push_back(w);
      end
    end
    ph     = (ph + 1) % 8;
    m_full = (occ == 16);
    m_offer = 1'b0;
    if (fq.size() > 0) begin
      if (fq[0].wr_edge < edge_no) m_offer = 1'b1;
    end
  endtask

  task automatic check_output();
    check("out_valid", 16'(out_valid), 16'(m_offer));
    if (m_offer) begin
      check("out_adr", 16'(out_adr), 16'(fq[0].adr));
      check("out_cnt", 16'(out_cnt), 16'(fq[0].cnt));
      check("out_sof", 16'(out_sof), 16'(fq[0].sof));
    end
    check("fifo_full", 16'(fifo_full), 16'(m_full));
    check("overflow", 16'(overflow), 16'(m_ovf));
    check("ovf_cnt", ovf_cnt, exp_ovf());
  endtask

  task automatic cycle();
    if (out_valid === 1'b1 && out_ready === 1'b1) hs++;
    @(posedge clock4x);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input int n, input int base, input bit rnd);
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        adr_in[i*11 +: 11] = rnd ? 11'($urandom_range(0, 1535)) : 11'(base + i);
        cnt_in[i*3 +: 3]   = rnd ? 3'($urandom_range(0, 7)) : 3'(i);
      end else begin
        adr_in[i*11 +: 11] = rnd ? {2'b11, 9'($urandom_range(0, 511))} : 11'h7FE;
        cnt_in[i*3 +: 3]   = 3'd0;
      end
    end
  endtask

  task automatic set_lane(input int i, input logic [10:0] a, input logic [2:0] c);
    adr_in[i*11 +: 11] = a;
    cnt_in[i*3 +: 3]   = c;
  endtask

  task automatic wait_capture();
    int guard;
    guard = 0;
    while ((ph % 4) != 3 && guard < 8) begin
      cycle();
      guard++;
    end
    check("capture_reached", 16'((ph % 4) == 3), 16'd1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    hs           = 0;
    edge_no      = 0;
    ph           = 1;
    occ          = 0;
    m_drops      = 0;
    m_full       = 1'b0;
    m_ovf        = 1'b0;
    m_offer      = 1'b0;
    global_reset = 1'b1;
    out_ready    = 1'b0;
    apply_stimulus(0, 0, 1'b0);

    // Reset state
    cycle();
    cycle();
    check("rst_out_adr", 16'(out_adr), 16'h0);
    check("rst_out_cnt", 16'(out_cnt), 16'h0);
    check("rst_out_sof", 16'(out_sof), 16'h0);
    global_reset = 1'b0;

    // All lanes invalid for 64 cycles
    repeat (64) cycle();
    check("idle_valid", 16'(out_valid), 16'h0);
    check("idle_overflow", 16'(overflow), 16'h0);

    // Two-cluster snapshot
    out_ready = 1'b1;
    hs = 0;
    wait_capture();
    apply_stimulus(0, 0, 1'b0);
    set_lane(0, 11'h010, 3'd2);
    set_lane(1, 11'h2A5, 3'd0);
    cycle();
    apply_stimulus(0, 0, 1'b0);
    cycle();
    check("two_e1_valid", 16'(out_valid), 16'h0);
    cycle();
    check("two_first_valid", 16'(out_valid), 16'h1);
    check("two_first_adr", 16'(out_adr), 16'h010);
    check("two_first_cnt", 16'(out_cnt), 16'h2);
    check("two_first_sof", 16'(out_sof), 16'h1);
    cycle();
    check("two_second_adr", 16'(out_adr), 16'h2A5);
    check("two_second_cnt", 16'(out_cnt), 16'h0);
    check("two_second_sof", 16'(out_sof), 16'h0);
    repeat (6) cycle();
    check("two_count", 16'(hs), 16'd2);

    // Eight consecutive clusters at 100..107
    hs = 0;
    wait_capture();
    apply_stimulus(8, 100, 1'b0);
    cycle();
    apply_stimulus(0, 0, 1'b0);
    repeat (12) cycle();
    check("eight_count", 16'(hs), 16'd8);

    // Fill with no consumer, then overflow
    out_ready = 1'b0;
    wait_capture();
    apply_stimulus(8, 0, 1'b1);
    for (int i = 0; i < 24; i++) cycle();
    apply_stimulus(0, 0, 1'b0);
    repeat (8) cycle();
    check("fill_full", 16'(fifo_full), 16'h1);
    check("fill_overflow", 16'(overflow), 16'h1);
`ifdef CLUSTER_PACKER_OVF_CNT_EN
    check("fill_ovf_cnt", ovf_cnt, 16'd8);
`else
    check("fill_ovf_cnt", ovf_cnt, 16'd0);
`endif
    out_ready = 1'b1;
    hs = 0;
    repeat (40) cycle();
    check("fill_drained", 16'(hs), 16'd32);
    check("fill_not_full", 16'(fifo_full), 16'h0);
    check("fill_sticky", 16'(overflow), 16'h1);

    // Backpressure on a five-lane snapshot
    hs = 0;
    wait_capture();
    apply_stimulus(5, 0, 1'b1);
    cycle();
    apply_stimulus(0, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      out_ready = ((i % 4) < 2);
      cycle();
    end
    check("bp_count", 16'(hs), 16'd5);
    out_ready = 1'b1;

    // Reset during PAIR2 of an eight-lane snapshot
    wait_capture();
    apply_stimulus(8, 300, 1'b0);
    cycle();
    cycle();
    cycle();
    global_reset = 1'b1;
    cycle();
    check("mid_rst_valid", 16'(out_valid), 16'h0);
    check("mid_rst_full", 16'(fifo_full), 16'h0);
    check("mid_rst_overflow", 16'(overflow), 16'h0);
    global_reset = 1'b0;
    cycle();
    cycle();
    cycle();
    apply_stimulus(0, 0, 1'b0);
    cycle();
    check("post_rst_quiet", 16'(out_valid), 16'h0);
    cycle();
    check("post_rst_valid", 16'(out_valid), 16'h1);
    check("post_rst_adr", 16'(out_adr), 16'd300);
    repeat (10) cycle();

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(int'($urandom_range(0, 8)), 0, 1'b1);
      out_ready    = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      global_reset = (i == 300);
      cycle();
    end
    global_reset = 1'b0;
    apply_stimulus(0, 0, 1'b0);
    out_ready = 1'b1;
    repeat (60) cycle();
    check("final_drained", 16'(out_valid), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_fifo_packer.md
# cluster_fifo_packer

Downstream stage of the 1536-strip first-8 cluster mux. It samples the eight multiplexed cluster lanes (11-bit address, 3-bit count) twice per 8-cycle `clock4x` frame, once per mux half. It compacts the valid lanes into a pair-wide FIFO and drains them as a single-cluster-per-cycle valid/ready stream toward the link formatter. FIFO overflow is flagged and, optionally, counted.

## Interface
- `FIFO_AW`, 4, log2 of FIFO depth in pair entries (depth 16 pairs = 32 clusters)
- `CAP_PHASE`, 2'd3, value of `phase[1:0]` on which lanes are sampled
- `clock4x`  in  1  sole clock
- `global_reset`  in  1  synchronous, active-high reset
- `adr_in`  in  88  `{adr7,...,adr0}`, 11 bits per lane
- `cnt_in`  in  24  `{cnt7,...,cnt0}`, 3 bits per lane
- `out_ready`  in  1  consumer accepts `out_*` this cycle
- `out_valid`  out  1  `out_adr`/`out_cnt`/`out_sof` hold a cluster
- `out_adr`  out  11  cluster address
- `out_cnt`  out  3  cluster size code
- `out_sof`  out  1  first cluster of a snapshot
- `fifo_full`  out  1  FIFO holds 2^FIFO_AW pairs
- `overflow`  out  1  sticky; a pair was dropped since reset
- `ovf_cnt`  out  16  dropped-pair count (see Configuration)

## Operation
- Phase counter: 3-bit, reset to 3'd1, +1 per cycle, wraps. Identical to the upstream mux counter, so both stay aligned from the same reset.
- Lane valid: `adr < 1536` (i.e. `adr[10:9] != 2'b11`). Upstream presents valid lanes contiguously from lane 0. The unloader stops at the first invalid lane.
- Capture: on a cycle with `phase[1:0]==CAP_PHASE`, all 8 lanes are registered into the snapshot. Per-lane valid bits are registered at the same time.
- Unloader: 4 states, PAIR0..PAIR3, plus IDLE.
  - Capture → PAIR0.
  - In PAIRk, lanes 2k and 2k+1 form a FIFO entry: 28 data bits, 2 valid bits, and an sof bit set only for k=0.
  - If lane 2k is invalid, nothing is pushed and the state goes to IDLE. Otherwise the entry is pushed and the state goes to PAIRk+1 (PAIR3 → IDLE).
  - A capture arriving in any state restarts at PAIR0 with the new snapshot. This happens in the same cycle as PAIR3 under the default phase spacing, and PAIR3 is still pushed from the old snapshot.
- Push when `fifo_full` is asserted: the entry is dropped, `overflow` is set, and `ovf_cnt` increments. The full test uses the registered full flag, so a pop in the same cycle does not rescue the push.
- Read side: first-word-fall-through.
  - Half select 0 presents the low cluster with its sof bit. Half select 1 presents the high cluster with `out_sof=0`.
  - A handshake (`out_valid & out_ready`) on the high half, or on the low half when the high valid bit is 0, pops the entry and returns half select to 0.
  - Output data is held stable while `out_valid & !out_ready`.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged.

## Timing
- Reset values: `out_valid=0`, `out_adr=0`, `out_cnt=0`, `out_sof=0`, `fifo_full=0`, `overflow=0`, `ovf_cnt=0`. FIFO empty, half select 0, unloader IDLE, phase 3'd1.
- Reset applied mid-unload discards the snapshot and all FIFO contents at the next edge.
- Capture edge E0 (lanes sampled). Pair k is written at edge E(1+k).
- With the FIFO empty and `out_ready=1`: `out_valid` rises after E2 and a snapshot of n valid lanes drains in n consecutive cycles.
- With the default `CAP_PHASE`, captures are 4 cycles apart, so the worst-case input is 8 clusters per 4 cycles against a drain of 4 per 4 cycles. Sustained full occupancy overflows by design.
- `fifo_full` and `overflow` are registered and are valid the cycle after the causing edge.

## Configuration
- `CLUSTER_PACKER_OVF_CNT_EN` defined: `ovf_cnt` is a 16-bit counter that saturates at 16'hFFFF. It counts dropped pairs and is cleared only by `global_reset`.
- Macro undefined: the counter logic is omitted and `ovf_cnt` is tied to 16'h0. `overflow` is unaffected.

## Test plan
- Reset, hold all lanes at `adr=11'h7FE` for 64 cycles → `out_valid` stays 0, `overflow=0`.
- One snapshot: lane0 `adr=11'h010`/`cnt=3'd2`, lane1 `adr=11'h2A5`/`cnt=3'd0`, lanes 2–7 invalid, `out_ready=1` → two clusters, `out_valid` rising 2 cycles after capture:
  - first: `11'h010`/2 with `out_sof=1`;
  - second: `11'h2A5`/0 with `out_sof=0`.
- Eight valid lanes at addresses 100..107, `out_ready=1` → 8 consecutive clusters in address order; sof only on 100.
- `out_ready=0`, 8 valid lanes every capture → `fifo_full=1` after the 4th capture. Next pair dropped → `overflow=1`, `ovf_cnt=1` (macro on) or 0 (macro off).
- Backpressure: toggle `out_ready` every other cycle during a 5-lane snapshot → each of the 5 clusters appears exactly once, data stable while stalled.
- Assert `global_reset` during PAIR2 of an 8-lane snapshot → next cycle FIFO empty, `out_valid=0`. Phase restarts at 1 and the next capture is at the 3rd cycle after reset.
